ttl_74x169_counter: RTL and testbench

- Parametrised synchronous presettable up/down counter in the 74x160/161/169 style; successor to the fixed combinational gate parts in the TTL library.
- Generalises width and modulus: 4-bit binary (74x161/169) and decade (74x160) are parameter settings.
- Cascadable through ENP/ENT and a ripple-carry output.
- Intended as a drop-in sequential TTL model for board-level netlists and as a building block for multi-stage counter chains.

---
 rtl/ttl_74x169_counter.sv | 49 ++++
 tb/tb_ttl_74x169_counter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_74x169_counter.sv
// Synchronous presettable up/down counter (74x160/161/169 style), parametrised width/modulus.
// Optional TTL_SYNC_CLEAR_EN adds SCLR_N, a 74x163-style synchronous active-low clear.
module ttl_74x169_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MODULUS = 16
) (
  input  logic             CLK,
  input  logic             CLR_N,
`ifdef TTL_SYNC_CLEAR_EN
  input  logic             SCLR_N,
`endif
  input  logic             LOAD_N,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             U_D,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO_N
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] up_next;
  logic [WIDTH-1:0] dn_next;
  logic [WIDTH-1:0] q_next;
  logic             tc;

  // Illegal states (Q > MAX_Q) snap to the wrap target of the current direction.
  // Ternaries keep X on the control inputs propagating into Q in simulation.
  always_comb begin
    up_next = (Q >= MAX_Q) ? '0 : Q + 1'b1;
    dn_next = ((Q == '0) || (Q > MAX_Q)) ? MAX_Q : Q - 1'b1;
    q_next  = LOAD_N ? ((ENP & ENT) ? (U_D ? up_next : dn_next) : Q) : D;
`ifdef TTL_SYNC_CLEAR_EN
    q_next  = SCLR_N ? q_next : '0;
`endif
  end

  always_comb begin
    tc    = U_D ? (Q == MAX_Q) : (Q == '0);
    RCO_N = ~(ENT & tc);
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) Q <= '0;
    else        Q <= q_next;
  end

endmodule

// File: tb/tb_ttl_74x169_counter.sv
// Directed self-checking bench for ttl_74x169_counter: mod-16, decade and a two-stage cascade.
module tb_ttl_74x169_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single mod-16 stage
  logic       a_clr_n = 1'b0, a_load_n = 1'b1, a_enp = 1'b0, a_ent = 1'b0, a_ud = 1'b1;
  logic       a_sclr_n = 1'b1;
  logic [3:0] a_d = '0;
  logic [3:0] a_q;
  logic       a_rco_n;

  // Decade stage
  logic       b_clr_n = 1'b0, b_load_n = 1'b1, b_enp = 1'b0, b_ent = 1'b0, b_ud = 1'b1;
  logic       b_sclr_n = 1'b1;
  logic [3:0] b_d = '0;
  logic [3:0] b_q;
  logic       b_rco_n;

  // Two-stage cascade
  logic       c_clr_n = 1'b0, c_enp = 1'b0, c_ent0 = 1'b0;
  logic       c_sclr_n = 1'b1;
  logic [3:0] c_q0, c_q1;
  logic       c_rco0_n, c_rco1_n;
  logic       c_ent1;
  assign c_ent1 = ~c_rco0_n;

  ttl_74x169_counter #(.WIDTH(4), .MODULUS(16)) dut_a (
    .CLK(clk), .CLR_N(a_clr_n),
`ifdef TTL_SYNC_CLEAR_EN
    .SCLR_N(a_sclr_n),
`endif
    .LOAD_N(a_load_n), .ENP(a_enp), .ENT(a_ent), .U_D(a_ud),
    .D(a_d), .Q(a_q), .RCO_N(a_rco_n)
  );

  ttl_74x169_counter #(.WIDTH(4), .MODULUS(10)) dut_b (
    .CLK(clk), .CLR_N(b_clr_n),
`ifdef TTL_SYNC_CLEAR_EN
    .SCLR_N(b_sclr_n),
`endif
    .LOAD_N(b_load_n), .ENP(b_enp), .ENT(b_ent), .U_D(b_ud),
    .D(b_d), .Q(b_q), .RCO_N(b_rco_n)
  );

  ttl_74x169_counter #(.WIDTH(4), .MODULUS(16)) dut_c0 (
    .CLK(clk), .CLR_N(c_clr_n),
`ifdef TTL_SYNC_CLEAR_EN
    .SCLR_N(c_sclr_n),
`endif
    .LOAD_N(1'b1), .ENP(c_enp), .ENT(c_ent0), .U_D(1'b1),
    .D(4'd0), .Q(c_q0), .RCO_N(c_rco0_n)
  );

  ttl_74x169_counter #(.WIDTH(4), .MODULUS(16)) dut_c1 (
    .CLK(clk), .CLR_N(c_clr_n),
`ifdef TTL_SYNC_CLEAR_EN
    .SCLR_N(c_sclr_n),
`endif
    .LOAD_N(1'b1), .ENP(c_enp), .ENT(c_ent1), .U_D(1'b1),
    .D(4'd0), .Q(c_q1), .RCO_N(c_rco1_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_ud = 1'b0;
    a_ent = 1'b1;
    #2;
    checks++;
    if (a_q !== 4'd0) begin errors++; $display("FAIL reset_q: got %0d want 0", a_q); end
    checks++;
    if (a_rco_n !== 1'b0) begin errors++; $display("FAIL reset_rco_down: got %b want 0", a_rco_n); end
    a_ud = 1'b1;
    #1;
    checks++;
    if (a_rco_n !== 1'b1) begin errors++; $display("FAIL reset_rco_up: got %b want 1", a_rco_n); end
    a_clr_n = 1'b1;
    a_enp   = 1'b1;
    repeat (7) tick();
    checks++;
    if (a_q !== 4'd7) begin errors++; $display("FAIL count_to_7: got %0d want 7", a_q); end
    #3;
    a_clr_n = 1'b0;
    #1;
    checks++;
    if (a_q !== 4'd0) begin errors++; $display("FAIL async_clear: got %0d want 0", a_q); end
    tick();
    checks++;
    if (a_q !== 4'd0) begin errors++; $display("FAIL clear_held: got %0d want 0", a_q); end
    a_clr_n = 1'b1;
    tick();
    checks++;
    if (a_q !== 4'd1) begin errors++; $display("FAIL first_edge_after_clear: got %0d want 1", a_q); end
  endtask

  task automatic test_decade_up();
    b_clr_n = 1'b1;
    b_ud = 1'b1; b_enp = 1'b1; b_ent = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (b_q !== 4'(i)) begin errors++; $display("FAIL decade_q[%0d]: got %0d want %0d", i, b_q, i); end
      checks++;
      if (b_rco_n !== (i == 9 ? 1'b0 : 1'b1))
        begin errors++; $display("FAIL decade_rco[%0d]: got %b want %b", i, b_rco_n, (i == 9 ? 1'b0 : 1'b1)); end
      tick();
    end
    checks++;
    if (b_q !== 4'd0) begin errors++; $display("FAIL decade_wrap: got %0d want 0", b_q); end
    repeat (9) tick();
    b_ent = 1'b0;
    #1;
    checks++;
    if (b_rco_n !== 1'b1) begin errors++; $display("FAIL ent_gates_rco: got %b want 1", b_rco_n); end
    tick();
    checks++;
    if (b_q !== 4'd9) begin errors++; $display("FAIL ent_hold: got %0d want 9", b_q); end
  endtask

  task automatic test_down();
    b_d = 4'd2; b_load_n = 1'b0; b_ud = 1'b0; b_enp = 1'b1; b_ent = 1'b1;
    tick();
    b_load_n = 1'b1;
    checks++;
    if (b_q !== 4'd2) begin errors++; $display("FAIL down_load2: got %0d want 2", b_q); end
    tick();
    checks++;
    if (b_q !== 4'd1) begin errors++; $display("FAIL down_1: got %0d want 1", b_q); end
    tick();
    checks++;
    if (b_q !== 4'd0) begin errors++; $display("FAIL down_0: got %0d want 0", b_q); end
    checks++;
    if (b_rco_n !== 1'b0) begin errors++; $display("FAIL borrow_rco: got %b want 0", b_rco_n); end
    b_enp = 1'b0;
    tick();
    checks++;
    if (b_q !== 4'd0) begin errors++; $display("FAIL enp_hold: got %0d want 0", b_q); end
    checks++;
    if (b_rco_n !== 1'b0) begin errors++; $display("FAIL enp_rco: got %b want 0", b_rco_n); end
    b_enp = 1'b1;
    tick();
    checks++;
    if (b_q !== 4'd9) begin errors++; $display("FAIL down_wrap: got %0d want 9", b_q); end
    b_ud = 1'b1;
    #1;
    checks++;
    if (b_rco_n !== 1'b0) begin errors++; $display("FAIL dir_change_rco: got %b want 0", b_rco_n); end
    tick();
    checks++;
    if (b_q !== 4'd0) begin errors++; $display("FAIL dir_change_q: got %0d want 0", b_q); end
  endtask

  task automatic test_load_illegal();
    b_d = 4'd13; b_load_n = 1'b0; b_ud = 1'b1; b_enp = 1'b1; b_ent = 1'b1;
    tick();
    checks++;
    if (b_q !== 4'd13) begin errors++; $display("FAIL load_13: got %0d want 13", b_q); end
    checks++;
    if (b_rco_n !== 1'b1) begin errors++; $display("FAIL illegal_rco: got %b want 1", b_rco_n); end
    b_load_n = 1'b1;
    tick();
    checks++;
    if (b_q !== 4'd0) begin errors++; $display("FAIL illegal_up: got %0d want 0", b_q); end
    b_load_n = 1'b0;
    tick();
    b_load_n = 1'b1; b_ud = 1'b0;
    checks++;
    if (b_q !== 4'd13) begin errors++; $display("FAIL reload_13: got %0d want 13", b_q); end
    tick();
    checks++;
    if (b_q !== 4'd9) begin errors++; $display("FAIL illegal_down: got %0d want 9", b_q); end
  endtask

  task automatic test_cascade();
    logic [7:0] exp_v;
    c_clr_n = 1'b1; c_enp = 1'b1; c_ent0 = 1'b1;
    exp_v = 8'h00;
    #1;
    for (int i = 0; i < 256; i++) begin
      checks++;
      if ({c_q1, c_q0} !== exp_v)
        begin errors++; $display("FAIL cascade_q[%0d]: got %02h want %02h", i, {c_q1, c_q0}, exp_v); end
      checks++;
      if (c_rco1_n !== (exp_v == 8'hFF ? 1'b0 : 1'b1))
        begin errors++; $display("FAIL cascade_rco1[%0d]: got %b want %b", i, c_rco1_n, (exp_v == 8'hFF ? 1'b0 : 1'b1)); end
      tick();
      exp_v = exp_v + 8'd1;
    end
    checks++;
    if ({c_q1, c_q0} !== 8'h00) begin errors++; $display("FAIL cascade_wrap: got %02h want 00", {c_q1, c_q0}); end
  endtask

`ifdef TTL_SYNC_CLEAR_EN
  task automatic test_sync_clear();
    a_clr_n = 1'b1; a_d = 4'd5; a_load_n = 1'b0;
    tick();
    checks++;
    if (a_q !== 4'd5) begin errors++; $display("FAIL sclr_preload: got %0d want 5", a_q); end
    a_sclr_n = 1'b0; a_d = 4'd3;
    #2;
    checks++;
    if (a_q !== 4'd5) begin errors++; $display("FAIL sclr_between_edges: got %0d want 5", a_q); end
    tick();
    checks++;
    if (a_q !== 4'd0) begin errors++; $display("FAIL sclr_over_load: got %0d want 0", a_q); end
    a_sclr_n = 1'b1; a_load_n = 1'b1;
  endtask
`endif

  initial begin
    test_reset();
    test_decade_up();
    test_down();
    test_load_illegal();
    test_cascade();
`ifdef TTL_SYNC_CLEAR_EN
    test_sync_clear();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
